// File: rtl/int_ctrl_pkg.sv
// Shared types and widths for the interrupt controller.
// The edge-sensitive variant is selected with INT_CTRL_EDGE_EN (see int_ctrl.sv).
package int_ctrl_pkg;

  localparam int unsigned INT_W    = 32;
  localparam int unsigned INT_ID_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SERVICE,
    FIN,
    DROP
  } int_state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over the first NUM_INT request lines.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INT = 32
) (
  input  logic [INT_W-1:0]    req,
  output logic [INT_ID_W-1:0] idx,
  output logic                valid
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = INT_ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: arbitrates device lines, presents one cause to the CPU,
// tracks trap entry/mret and returns a finish pulse. Define INT_CTRL_EDGE_EN for edge mode.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INT = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [INT_W-1:0]    int_req_i,
  input  logic [INT_W-1:0]    int_mask_i,
  output logic [INT_W-1:0]    int_fin_o,
  output logic                irq_o,
  output logic [INT_ID_W-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic                irq_ret_i,
  output logic                busy_o
);

  localparam logic [INT_W-1:0] LINE_MASK = INT_W'((64'd1 << NUM_INT) - 64'd1);

  int_state_t          state_q;
  logic [INT_ID_W-1:0] id_q;
  logic [INT_W-1:0]    src;
  logic [INT_W-1:0]    eff;
  logic [INT_W-1:0]    id_onehot;
  logic [INT_ID_W-1:0] win_id;
  logic                win_vld;

  assign id_onehot = LINE_MASK & (INT_W'(1) << id_q);

`ifdef INT_CTRL_EDGE_EN
  logic [INT_W-1:0] prev_q;
  logic [INT_W-1:0] pend_q;
  logic [INT_W-1:0] fin_clr;

  // Pending bits latch rising edges and are released only when their service finishes.
  assign fin_clr = (state_q == FIN) ? id_onehot : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= int_req_i & LINE_MASK;
      pend_q <= (pend_q & ~fin_clr) | (int_req_i & ~prev_q & LINE_MASK);
    end
  end

  assign src = pend_q;
`else
  assign src = int_req_i;
`endif

  assign eff = src & int_mask_i & LINE_MASK;

  int_prio_enc #(
    .NUM_INT (NUM_INT)
  ) u_prio_enc (
    .req   (eff),
    .idx   (win_id),
    .valid (win_vld)
  );

  assign irq_id_o = id_q;

  // Control FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      irq_o     <= 1'b0;
      busy_o    <= 1'b0;
      int_fin_o <= '0;
    end else begin
      int_fin_o <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= REQ;
            id_q    <= win_id;
            irq_o   <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        REQ: begin
          // A trap already taken outranks a line withdrawn in the same cycle.
          if (irq_ack_i) begin
            state_q <= SERVICE;
            irq_o   <= 1'b0;
          end else if (!eff[id_q]) begin
            state_q <= IDLE;
            irq_o   <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_ret_i) begin
            state_q   <= FIN;
            int_fin_o <= id_onehot;
          end
        end
        FIN: begin
`ifdef INT_CTRL_EDGE_EN
          state_q <= IDLE;
          busy_o  <= 1'b0;
`else
          state_q <= DROP;
`endif
        end
`ifndef INT_CTRL_EDGE_EN
        DROP: begin
          // Hold off until the device lets go, so a still-high line is not re-serviced.
          if (!int_req_i[id_q]) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          irq_o   <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  a_fin_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(int_fin_o));
  a_irq_busy:   assert property (@(posedge clk) disable iff (!rstn) irq_o |-> busy_o);

endmodule
